// File: rtl/fp_class_pkg.sv
// Shared FCLASS.D definitions, common to the classifier and the class generator.
// Holds class index constants, IEEE-754 double field positions and the FSM state type.
package fp_class_pkg;
  localparam int NUM_CLASSES = 10;

  localparam logic [3:0] CLS_NINF  = 4'd0;
  localparam logic [3:0] CLS_NNORM = 4'd1;
  localparam logic [3:0] CLS_NSUB  = 4'd2;
  localparam logic [3:0] CLS_NZERO = 4'd3;
  localparam logic [3:0] CLS_PZERO = 4'd4;
  localparam logic [3:0] CLS_PSUB  = 4'd5;
  localparam logic [3:0] CLS_PNORM = 4'd6;
  localparam logic [3:0] CLS_PINF  = 4'd7;
  localparam logic [3:0] CLS_SNAN  = 4'd8;
  localparam logic [3:0] CLS_QNAN  = 4'd9;

  localparam logic [10:0] EXP_MAX = 11'h7FF;
  localparam int SIGN_BIT = 63;
  localparam int EXP_MSB  = 62;
  localparam int EXP_LSB  = 52;
  localparam int MANT_MSB = 51;
  localparam int QNAN_BIT = 51;

  typedef enum logic {ST_IDLE, ST_GEN} gen_state_e;

  function automatic logic [NUM_CLASSES-1:0] cls_onehot(input logic [3:0] c);
    return {{(NUM_CLASSES-1){1'b0}}, 1'b1} << c;
  endfunction
endpackage

// File: rtl/fp_class_gen_d_if.sv
// Request / beat bus of the FCLASS.D stimulus generator.
// master: requester + beat consumer; slave: the generator.
interface fp_class_gen_d_if #(parameter int COUNT_W = 8);
  import fp_class_pkg::*;
  logic                   req_valid;
  logic                   req_ready;
  logic [3:0]             req_class;
  logic [COUNT_W-1:0]     req_count;
  logic                   seed_wr;
  logic [63:0]            seed_val;
  logic                   out_valid;
  logic                   out_ready;
  logic [63:0]            out_d;
  logic [NUM_CLASSES-1:0] out_flags;
  logic                   out_last;
  logic                   out_err;

  modport master (output req_valid, req_class, req_count, seed_wr, seed_val, out_ready,
                  input  req_ready, out_valid, out_d, out_flags, out_last, out_err);
  modport slave  (input  req_valid, req_class, req_count, seed_wr, seed_val, out_ready,
                  output req_ready, out_valid, out_d, out_flags, out_last, out_err);
endinterface

// File: rtl/fp_class_gen_d_lfsr.sv
// fp_lfsr64: 64-bit Fibonacci LFSR, x^64+x^63+x^61+x^60+1, shift-left, feedback into bit 0.
// Ports: clk, rst (async high), load_i/load_val_i (load, 0 -> 1), adv_i (one step), state_o.
module fp_lfsr64 #(
  parameter logic [63:0] SEED = 64'hACE1_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  input  logic        adv_i,
  output logic [63:0] state_o
);
  // An all-zero state would lock the register up, so both reset and load guard it.
  localparam logic [63:0] SEED_G = (SEED == 64'd0) ? 64'd1 : SEED;

  logic [63:0] lfsr_q;
  logic        fb;

  assign fb      = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];
  assign state_o = lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr_q <= SEED_G;
    else if (load_i)  lfsr_q <= (load_val_i == 64'd0) ? 64'd1 : load_val_i;
    else if (adv_i)   lfsr_q <= {lfsr_q[62:0], fb};
  end
endmodule

// File: rtl/fp_class_gen_d.sv
// fp_class_gen_d: burst generator of doubles guaranteed to fall in a requested FCLASS.D class.
// Ports: clk, rst (async high), gen_if (slave): request side req_valid/req_ready/req_class/
//   req_count/seed_wr/seed_val, beat side out_valid/out_ready/out_d/out_flags/out_last/out_err.
// Burst length is req_count+1; a class index above 9 yields a single error beat.
module fp_class_gen_d
  import fp_class_pkg::*;
#(
  parameter int          COUNT_W = 8,
  parameter logic [63:0] SEED    = 64'hACE1_0000_0000_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_class_gen_d_if.slave      gen_if
);
  gen_state_e         state_q;
  logic [3:0]         cls_q;
  logic               err_q;
  logic [COUNT_W-1:0] rem_q;
  logic [63:0]        r;
  logic [63:0]        beat_d;
  logic               gen, accept, hs, bad_cls;

  assign gen     = (state_q == ST_GEN);
  assign bad_cls = (gen_if.req_class > CLS_QNAN);
  assign accept  = gen_if.req_valid && gen_if.req_ready;
  assign hs      = gen && gen_if.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cls_q   <= 4'd0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q <= ST_GEN;
          cls_q   <= gen_if.req_class;
          err_q   <= bad_cls;
          rem_q   <= bad_cls ? '0 : gen_if.req_count;
        end
        ST_GEN: if (hs) begin
          if (rem_q == '0) state_q <= ST_IDLE;
          else             rem_q   <= rem_q - COUNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Seed writes only land in IDLE; the same-cycle request then sees the new value on beat one.
  fp_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (!gen && gen_if.seed_wr),
    .load_val_i (gen_if.seed_val),
    .adv_i      (hs),
    .state_o    (r)
  );

  // Beat construction: the random bits are forced into the legal range of the latched class.
  always_comb begin
    logic        s;
    logic [10:0] e;
    logic [51:0] m;
    s = 1'b0;
    e = 11'd0;
    m = 52'd0;
    case (cls_q)
      CLS_NINF, CLS_PINF: begin
        s = (cls_q == CLS_NINF);
        e = EXP_MAX;
      end
      CLS_NNORM, CLS_PNORM: begin
        s = (cls_q == CLS_NNORM);
        e = r[EXP_MSB:EXP_LSB];
        if (e == 11'd0)        e = 11'd1;
        else if (e == EXP_MAX) e = EXP_MAX - 11'd1;
        m = r[MANT_MSB:0];
      end
      CLS_NSUB, CLS_PSUB: begin
        s = (cls_q == CLS_NSUB);
        m = (r[MANT_MSB:0] == 52'd0) ? 52'd1 : r[MANT_MSB:0];
      end
      CLS_NZERO: s = 1'b1;
      CLS_SNAN: begin
        s = r[SIGN_BIT];
        e = EXP_MAX;
        m = {1'b0, (r[QNAN_BIT-1:0] == 51'd0) ? 51'd1 : r[QNAN_BIT-1:0]};
      end
      CLS_QNAN: begin
        s = r[SIGN_BIT];
        e = EXP_MAX;
        m = {1'b1, r[QNAN_BIT-1:0]};
      end
      default: ;
    endcase
    beat_d = err_q ? 64'd0 : {s, e, m};
  end

  // Outputs are gated by the GEN state so every beat field reads 0 between bursts.
  assign gen_if.req_ready = !gen && !rst;
  assign gen_if.out_valid = gen;
  assign gen_if.out_d     = gen ? beat_d : 64'd0;
  assign gen_if.out_flags = (gen && !err_q) ? cls_onehot(cls_q) : '0;
  assign gen_if.out_last  = gen && (rem_q == '0);
  assign gen_if.out_err   = gen && err_q;
endmodule
